// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: round-robin, packet-atomic merge of NUM_INPUTS commit
// streams onto one commit channel, with a 2-entry output-registered skid buffer.
module vx_commit_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned PERF_WIDTH = 32,
    localparam int unsigned SRC_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_sop,
    input  logic [NUM_INPUTS-1:0]            in_eop,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_sop,
    output logic                             out_eop,
    input  logic                             out_ready,
    output logic [SRC_W-1:0]                 out_src,
    output logic [PERF_WIDTH-1:0]            perf_stalls
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // One buffered commit beat; the source index travels with the payload.
    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [SRC_W-1:0]      src;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] lock_id_q, lock_id_d;
    logic             en_q;

    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] grant_next;
    logic             found;
    logic             sel_valid;
    logic             sel_sop;
    logic             sel_eop;
    logic [DATA_WIDTH-1:0] sel_data;
    logic             accept;
    logic             pop;

    beat_t            push_beat;
    beat_t            head_q;
    beat_t            tail_q;
    logic             head_valid_q;
    logic             tail_valid_q;
    logic             skid_full;
    logic [PERF_WIDTH-1:0] perf_q;

    assign skid_full = tail_valid_q;
    assign pop       = head_valid_q & out_ready;

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Holds in_ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // Arbiter next state: lock on a multi-beat sop, release on eop, advance rr pointer.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    rr_ptr_d = grant_next;
                    if (sel_sop && !sel_eop) begin
                        state_d   = ST_LOCKED;
                        lock_id_d = grant;
                    end
                end
                ST_LOCKED: begin
                    if (sel_eop) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_next;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Arbiter outputs: grant selection, per-requester ready, selected beat mux.
    // With no requester valid in IDLE the grant rests on rr_ptr.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant = lock_id_q;
        end else begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                if (!found && in_valid[i] && (SRC_W'(i) >= rr_ptr_q)) begin
                    grant = SRC_W'(i);
                    found = 1'b1;
                end
            end
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                if (!found && in_valid[i]) begin
                    grant = SRC_W'(i);
                    found = 1'b1;
                end
            end
        end

        grant_next = (32'(grant) == NUM_INPUTS - 1) ? '0 : grant + SRC_W'(1);

        in_ready  = '0;
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            if (grant == SRC_W'(i)) begin
                in_ready[i] = en_q & ~skid_full;
                sel_valid   = in_valid[i];
                sel_sop     = in_sop[i];
                sel_eop     = in_eop[i];
                sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        accept = sel_valid & en_q & ~skid_full;

        push_beat.sop  = sel_sop;
        push_beat.eop  = sel_eop;
        push_beat.src  = grant;
        push_beat.data = sel_data;
    end

    // Skid buffer: head drives the outputs, tail absorbs one beat of backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            head_valid_q <= 1'b0;
            tail_valid_q <= 1'b0;
        end else if (tail_valid_q) begin
            if (pop) begin
                head_q       <= tail_q;
                tail_valid_q <= 1'b0;
            end
        end else if (head_valid_q) begin
            if (accept && pop) begin
                head_q <= push_beat;
            end else if (accept) begin
                tail_q       <= push_beat;
                tail_valid_q <= 1'b1;
            end else if (pop) begin
                head_valid_q <= 1'b0;
            end
        end else if (accept) begin
            head_q       <= push_beat;
            head_valid_q <= 1'b1;
        end
    end

    // Saturating count of cycles where the output is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (head_valid_q && !out_ready && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_WIDTH'(1);
        end
    end

    assign out_valid   = head_valid_q;
    assign out_data    = head_q.data;
    assign out_sop     = head_q.sop;
    assign out_eop     = head_q.eop;
    assign out_src     = head_q.src;
    assign perf_stalls = perf_q;

    // A new sop from the lock owner means upstream broke packet framing.
    lock_sop_chk : assert property (@(posedge clk) disable iff (!reset)
        !((state_q == ST_LOCKED) && accept && sel_sop))
        else $error("vx_commit_arbiter: sop accepted while locked");

endmodule
